// File: rtl/memory_responder.sv
// Word-addressed main memory answering MAR/MDR requests after a fixed latency.
// Optional address range checking is enabled with `define MEM_ADDR_CHECK_EN.
module memory_responder #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 512,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [31:0]           mar_addr,
    input  logic [DATA_WIDTH-1:0] mdr_wdata,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_done,
    output logic                  mem_busy,
    output logic                  mem_err
);

    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    op_wr_q, op_wr_d;
    logic [31:0]             addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    in_range;
    logic                    access;
    logic [ADDR_WIDTH-1:0]   idx;

    logic [DATA_WIDTH-1:0]   ram [DEPTH];

    assign idx    = addr_q[ADDR_WIDTH-1:0];
    assign access = (state_q == WAIT) && (cnt_q == '0);

`ifdef MEM_ADDR_CHECK_EN
    assign in_range = (addr_q < DEPTH);
`else
    // Upper address bits are ignored so accesses wrap modulo DEPTH.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_q[31:ADDR_WIDTH];
    assign in_range       = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    op_wr_d = mem_write;
                    addr_d  = mar_addr;
                    wdata_d = mdr_wdata;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    err_d   = ~in_range;
                    if (!op_wr_q) begin
                        rdata_d = in_range ? ram[idx] : '0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Storage is not reset; a reset during WAIT forces IDLE so no write fires.
    always_ff @(posedge clock) begin
        if (access && op_wr_q && in_range) begin
            ram[idx] <= wdata_q;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_done  = done_q;
    assign mem_err   = err_q;
    assign mem_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_memory_responder.sv
// Directed, table-driven bench for memory_responder at LATENCY=2.
// Expectations for out-of-range cases follow `define MEM_ADDR_CHECK_EN.
module tb_memory_responder;

    logic        clock = 1'b0;
    logic        clear;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mar_addr;
    logic [31:0] mdr_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        mem_busy;
    logic        mem_err;

    int total = 0;
    int bad   = 0;

    memory_responder #(
        .DATA_WIDTH(32),
        .DEPTH     (512),
        .ADDR_WIDTH(9),
        .LATENCY   (2)
    ) dut (
        .clock    (clock),
        .clear    (clear),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mar_addr (mar_addr),
        .mdr_wdata(mdr_wdata),
        .mem_rdata(mem_rdata),
        .mem_done (mem_done),
        .mem_busy (mem_busy),
        .mem_err  (mem_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    // One request; live inputs are scrambled after accept to prove latching.
    task automatic xact(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output int busy_cyc, output int done_w);
        @(negedge clock);
        mem_read  = rd;
        mem_write = wr;
        mar_addr  = a;
        mdr_wdata = d;
        @(posedge clock);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mar_addr  = ~a;
        mdr_wdata = ~d;
        lat      = -1;
        done_w   = 0;
        rdata    = 'x;
        err      = 1'bx;
        busy_cyc = mem_busy ? 1 : 0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clock);
            #1;
            if (mem_done) begin
                done_w++;
                if (lat < 0) begin
                    lat   = e;
                    rdata = mem_rdata;
                    err   = mem_err;
                end
            end
            if (mem_busy) busy_cyc++;
        end
    endtask

    initial begin
        logic [31:0] rd_v;
        logic        err_v;
        int          lat, busy_c, done_w, seen;

        vecs[0]  = '{1'b0, 1'b1, 32'h010, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'd511, 32'h1,        32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 32'd0,   32'h2,        32'hDEADBEEF, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'd511, 32'h0,        32'h1,        1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'd0,   32'h0,        32'h2,        1'b0};
        vecs[6]  = '{1'b0, 1'b1, 32'd0,   32'h0,        32'h2,        1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'd0,   32'h0,        32'h0,        1'b0};
        vecs[8]  = '{1'b1, 1'b1, 32'd5,   32'hA5A5A5A5, 32'h0,        1'b0};
        vecs[9]  = '{1'b1, 1'b0, 32'd5,   32'h0,        32'hA5A5A5A5, 1'b0};
`ifdef MEM_ADDR_CHECK_EN
        vecs[10] = '{1'b0, 1'b1, 32'h200, 32'h0000FFFF, 32'hA5A5A5A5, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 32'd0,   32'h0,        32'h0,        1'b0};
        vecs[12] = '{1'b1, 1'b0, 32'h200, 32'h0,        32'h0,        1'b1};
`else
        vecs[10] = '{1'b0, 1'b1, 32'h200, 32'h0000FFFF, 32'hA5A5A5A5, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 32'd0,   32'h0,        32'h0000FFFF, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 32'h200, 32'h0,        32'h0000FFFF, 1'b0};
`endif

        clear     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mar_addr  = '0;
        mdr_wdata = '0;

        // Reset held, then released mid-cycle with no strobes.
        #12;
        chk("rst_rdata", mem_rdata, 32'h0);
        chk("rst_done",  32'(mem_done), 32'h0);
        chk("rst_busy",  32'(mem_busy), 32'h0);
        chk("rst_err",   32'(mem_err),  32'h0);
        @(negedge clock);
        #2;
        clear = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            if (mem_busy || mem_done) seen++;
        end
        chk("idle_no_activity", 32'(seen), 32'h0);

        for (int i = 0; i < 13; i++) begin
            xact(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd_v, err_v, lat, busy_c, done_w);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
            chk($sformatf("v%0d_done_width", i), 32'(done_w), 32'd1);
            chk($sformatf("v%0d_busy_cycles", i), 32'(busy_c), 32'd3);
            chk($sformatf("v%0d_rdata", i), rd_v, vecs[i].exp_rdata);
            chk($sformatf("v%0d_err", i), 32'(err_v), 32'(vecs[i].exp_err));
        end

        // Write aborted by reset during WAIT must leave RAM[7] untouched.
        xact(1'b0, 1'b1, 32'd7, 32'h11111111, rd_v, err_v, lat, busy_c, done_w);
        chk("pre_abort_done", 32'(done_w), 32'd1);
        @(negedge clock);
        mem_write = 1'b1;
        mar_addr  = 32'd7;
        mdr_wdata = 32'h12345678;
        @(posedge clock);
        #1;
        mem_write = 1'b0;
        chk("abort_busy_wait", 32'(mem_busy), 32'h1);
        @(posedge clock);
        #1;
        clear = 1'b0;
        #1;
        chk("abort_busy_cleared", 32'(mem_busy), 32'h0);
        chk("abort_rdata_cleared", mem_rdata, 32'h0);
        @(negedge clock);
        #2;
        clear = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            if (mem_done || mem_busy) seen++;
        end
        chk("abort_no_done", 32'(seen), 32'h0);
        xact(1'b1, 1'b0, 32'd7, 32'h0, rd_v, err_v, lat, busy_c, done_w);
        chk("abort_read_latency", 32'(lat), 32'd2);
        chk("abort_read_rdata", rd_v, 32'h11111111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
